nec_decode_pipe: RTL and testbench

//  Parametrised, free-running V30-family instruction decoder between the prefetch queue (IPQ) and execute.

---
 rtl/nec_decode_pipe_pkg.sv | 112 +++++++++++
 rtl/nec_decode_pipe_fifo.sv | 55 +++++
 rtl/nec_decode_pipe.sv | 183 ++++++++++++++++++
 tb/tb_nec_decode_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nec_decode_pipe_pkg.sv
// Shared types, opcode table and operand-sizing helpers for the V30 decode pipe.
package nec_decode_pipe_pkg;

  typedef enum logic [1:0] {INIT, OPCODE, OPERANDS, EMIT} dec_pipe_stage_e;
  typedef enum logic [1:0] {DS1, PS, SS, DS0} seg_e;
  typedef enum logic [2:0] {REPEAT_NONE, REPEAT_Z, REPEAT_NZ, REPEAT_C, REPEAT_NC} rep_e;
  typedef enum logic [3:0] {
    OP_INVALID, OP_NOP, OP_HALT, OP_MOVBK, OP_MOV_RI, OP_MOV, OP_LDEA, OP_ALU_I, OP_PUSH_I, OP_PREPARE
  } op_e;
  typedef enum logic [1:0] {IMM_NONE, IMM, IMM8, IMM_EXT} imm_e;
  typedef enum logic [1:0] {W8, W16, W32} width_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] end_pc;
    op_e         opcode;
    width_e      width;
    seg_e        segment;
    logic        buslock;
    rep_e        rep;
    logic [7:0]  modrm;
    logic [15:0] disp;
    logic [31:0] imm;
    logic        mem_read;
    logic        mem_write;
  } nec_decode_t;

  typedef struct packed {
    nec_decode_t d;
    logic        fault;
    logic [3:0]  prefix_count;
  } nec_decode_entry_t;

  typedef struct packed {
    logic       hit;
    op_e        op;
    logic [2:0] size;   // opcode byte plus ModRM when present
    logic       modrm;
    imm_e       imm;
    width_e     w;
    logic       mrd;
    logic       mwr;
  } op_info_t;

  function automatic op_info_t op_info(op_e op, logic [2:0] size, logic modrm, imm_e imm,
                                       width_e w, logic mrd, logic mwr);
    return '{1'b1, op, size, modrm, imm, w, mrd, mwr};
  endfunction

  function automatic op_info_t op_lookup(logic [7:0] b);
    op_lookup = '0;
    casez (b)
      8'h90:        op_lookup = op_info(OP_NOP,     3'd1, 1'b0, IMM_NONE, W8,  1'b0, 1'b0);
      8'hF4:        op_lookup = op_info(OP_HALT,    3'd1, 1'b0, IMM_NONE, W8,  1'b0, 1'b0);
      8'hA4:        op_lookup = op_info(OP_MOVBK,   3'd1, 1'b0, IMM_NONE, W8,  1'b0, 1'b0);
      8'b1011_0???: op_lookup = op_info(OP_MOV_RI,  3'd1, 1'b0, IMM,      W8,  1'b0, 1'b0);
      8'b1011_1???: op_lookup = op_info(OP_MOV_RI,  3'd1, 1'b0, IMM,      W16, 1'b0, 1'b0);
      8'h88:        op_lookup = op_info(OP_MOV,     3'd2, 1'b1, IMM_NONE, W8,  1'b0, 1'b1);
      8'h89:        op_lookup = op_info(OP_MOV,     3'd2, 1'b1, IMM_NONE, W16, 1'b0, 1'b1);
      8'h8A:        op_lookup = op_info(OP_MOV,     3'd2, 1'b1, IMM_NONE, W8,  1'b1, 1'b0);
      8'h8B:        op_lookup = op_info(OP_MOV,     3'd2, 1'b1, IMM_NONE, W16, 1'b1, 1'b0);
      8'h8D:        op_lookup = op_info(OP_LDEA,    3'd2, 1'b1, IMM_NONE, W16, 1'b1, 1'b0);
      8'h83:        op_lookup = op_info(OP_ALU_I,   3'd2, 1'b1, IMM_EXT,  W16, 1'b1, 1'b1);
      8'h6A:        op_lookup = op_info(OP_PUSH_I,  3'd1, 1'b0, IMM8,     W16, 1'b0, 1'b0);
      8'hC8:        op_lookup = op_info(OP_PREPARE, 3'd1, 1'b0, IMM_NONE, W16, 1'b0, 1'b0);
      default:      op_lookup = '0;
    endcase
  endfunction

  function automatic logic is_prefix(logic [7:0] b);
    case (b)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF3, 8'hF2, 8'h65, 8'h64: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] calc_disp_size(logic [7:0] modrm);
    case (modrm[7:6])
      2'b00:   return (modrm[2:0] == 3'b110) ? 2'd2 : 2'd0;
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] calc_imm_size(imm_e k, width_e w, op_e op);
    if (op == OP_PREPARE) return 3'd3;
    case (k)
      IMM:           return (w == W8) ? 3'd1 : (w == W16) ? 3'd2 : 3'd4;
      IMM8, IMM_EXT: return 3'd1;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic seg_e calc_seg(logic [7:0] modrm);
    case (modrm[2:0])
      3'b010, 3'b011: return SS;
      3'b110:         return (modrm[7:6] == 2'b00) ? DS0 : SS;
      default:        return DS0;
    endcase
  endfunction

  function automatic nec_decode_t fresh_record(logic [15:0] pc);
    nec_decode_t r;
    r         = '0;
    r.pc      = pc;
    r.segment = DS0;
    r.rep     = REPEAT_NONE;
    return r;
  endfunction

endpackage

// File: rtl/nec_decode_pipe_fifo.sv
// Output record FIFO: count-based full/empty, synchronous flush, head shown combinationally.
module nec_decode_fifo
  import nec_decode_pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  nec_decode_entry_t din,
  output nec_decode_entry_t dout,
  output logic              full,
  output logic              empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  nec_decode_entry_t mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
endmodule

// File: rtl/nec_decode_pipe.sv
// Free-running V30 decoder: prefix/opcode/operand stages feeding a small record FIFO.
module nec_decode_pipe
  import nec_decode_pipe_pkg::*;
#(
  parameter  int IPQ_DEPTH  = 8,
  parameter  int OUT_DEPTH  = 2,
  parameter  int MAX_PREFIX = 15,
  localparam int IPQ_AW     = $clog2(IPQ_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ce,
  input  logic                       set_pc,
  input  logic [15:0]                new_pc,
  input  logic [IPQ_AW:0]            ipq_len,
  input  logic [IPQ_DEPTH-1:0][7:0]  ipq,
  output logic [15:0]                pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output nec_decode_entry_t          out_entry,
  output logic                       idle
);
  localparam int LW = IPQ_AW + 1;

  dec_pipe_stage_e stage, stage_n;
  nec_decode_t     d, d_n;
  logic [15:0]     pc_n;
  logic            seg_ovr, seg_ovr_n, fault, fault_n;
  logic [3:0]      pcnt, pcnt_n;
  logic            has_modrm, has_modrm_n, mrd, mrd_n, mwr, mwr_n;
  imm_e            imm_k, imm_k_n;
  logic            push, push_s, pop, flush, full, empty;
  logic [7:0]      opb [0:5];
  op_info_t        cur;
  logic [1:0]      dsz;
  logic [2:0]      isz;
  logic [3:0]      opnd;

  always_comb
    for (int k = 0; k < 6; k++) opb[k] = ipq[pc[IPQ_AW-1:0] + IPQ_AW'(k)];

  assign cur  = op_lookup(opb[0]);
  assign dsz  = has_modrm ? calc_disp_size(d.modrm) : 2'd0;
  assign isz  = calc_imm_size(imm_k, d.width, d.opcode);
  assign opnd = {2'b00, dsz} + {1'b0, isz};

  always_comb begin
    stage_n     = stage;
    pc_n        = pc;
    d_n         = d;
    seg_ovr_n   = seg_ovr;
    pcnt_n      = pcnt;
    fault_n     = fault;
    has_modrm_n = has_modrm;
    mrd_n       = mrd;
    mwr_n       = mwr;
    imm_k_n     = imm_k;
    push        = 1'b0;
    case (stage)
      INIT: begin
        d_n       = fresh_record(pc);
        seg_ovr_n = 1'b0;
        pcnt_n    = '0;
        fault_n   = 1'b0;
        stage_n   = OPCODE;
      end
      OPCODE: if (ipq_len != '0) begin
        if (is_prefix(opb[0])) begin
          if (pcnt == 4'(MAX_PREFIX)) begin
            // Chain too long: leave the byte in place so the next decode restarts on it
            fault_n     = 1'b1;
            d_n.opcode  = OP_INVALID;
            d_n.end_pc  = pc;
            stage_n     = EMIT;
          end else begin
            pc_n   = pc + 16'd1;
            pcnt_n = pcnt + 4'd1;
            case (opb[0])
              8'h26:   begin d_n.segment = DS1; seg_ovr_n = 1'b1; end
              8'h2E:   begin d_n.segment = PS;  seg_ovr_n = 1'b1; end
              8'h36:   begin d_n.segment = SS;  seg_ovr_n = 1'b1; end
              8'h3E:   begin d_n.segment = DS0; seg_ovr_n = 1'b1; end
              8'hF0:   d_n.buslock = 1'b1;
              8'hF3:   d_n.rep = REPEAT_Z;
              8'hF2:   d_n.rep = REPEAT_NZ;
              8'h65:   d_n.rep = REPEAT_C;
              default: d_n.rep = REPEAT_NC;
            endcase
          end
        end else if (cur.hit) begin
          if (ipq_len >= LW'(cur.size)) begin
            pc_n        = pc + 16'(cur.size);
            d_n.opcode  = cur.op;
            d_n.width   = cur.w;
            d_n.modrm   = cur.modrm ? opb[1] : 8'h00;
            has_modrm_n = cur.modrm;
            mrd_n       = cur.mrd;
            mwr_n       = cur.mwr;
            imm_k_n     = cur.imm;
            stage_n     = OPERANDS;
          end
        end else begin
          d_n.opcode = OP_INVALID;
          d_n.end_pc = pc + 16'd1;
          pc_n       = pc + 16'd1;
          stage_n    = EMIT;
        end
      end
      OPERANDS: if (ipq_len >= LW'(opnd)) begin
        d_n.disp = {opb[1], opb[0]};
        for (int j = 0; j < 4; j++)
          d_n.imm[8*j +: 8] = (3'(j) < isz) ? opb[int'(dsz) + j] : 8'h00;
        d_n.end_pc = pc + 16'(opnd);
        pc_n       = pc + 16'(opnd);
        if (has_modrm && d.modrm[7:6] != 2'b11 && d.opcode != OP_LDEA) begin
          d_n.mem_read  = mrd;
          d_n.mem_write = mwr;
        end
        if (has_modrm && !seg_ovr) d_n.segment = calc_seg(d.modrm);
        stage_n = EMIT;
      end
      default: if (!full || pop) begin
        push      = 1'b1;
        d_n       = fresh_record(pc);
        seg_ovr_n = 1'b0;
        pcnt_n    = '0;
        fault_n   = 1'b0;
        stage_n   = OPCODE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage     <= INIT;
      pc        <= '0;
      d         <= '0;
      seg_ovr   <= 1'b0;
      pcnt      <= '0;
      fault     <= 1'b0;
      has_modrm <= 1'b0;
      mrd       <= 1'b0;
      mwr       <= 1'b0;
      imm_k     <= IMM_NONE;
    end else if (ce) begin
      if (set_pc) begin
        stage <= INIT;
        pc    <= new_pc;
      end else begin
        stage     <= stage_n;
        pc        <= pc_n;
        d         <= d_n;
        seg_ovr   <= seg_ovr_n;
        pcnt      <= pcnt_n;
        fault     <= fault_n;
        has_modrm <= has_modrm_n;
        mrd       <= mrd_n;
        mwr       <= mwr_n;
        imm_k     <= imm_k_n;
      end
    end
  end

  // set_pc wins over both FIFO strobes; a pop offered during a flush is dropped
  assign flush  = ce && set_pc;
  assign pop    = ce && !set_pc && out_ready && !empty;
  assign push_s = ce && !set_pc && push;

  nec_decode_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop),
    .din     ('{d: d, fault: fault, prefix_count: pcnt}),
    .dout    (out_entry),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign idle      = empty && stage == OPCODE && ipq_len == '0;
endmodule

// File: tb/tb_nec_decode_pipe.sv
// Scoreboard bench: a byte-memory IPQ model feeds the decoder, expected records are queued and popped on handshake.
module tb_nec_decode_pipe;
  import nec_decode_pipe_pkg::*;

  localparam int IPQ_DEPTH = 8, OUT_DEPTH = 2, MAX_PREFIX = 15;

  logic clk = 1'b0, reset_n = 1'b0, ce = 1'b1, set_pc = 1'b0, out_ready = 1'b0;
  logic [15:0] new_pc = '0, pc, diff;
  logic [3:0]  ipq_len;
  logic [IPQ_DEPTH-1:0][7:0] ipq;
  logic out_valid, idle;
  nec_decode_entry_t out_entry;

  logic [7:0]  mem [0:65535];
  logic [15:0] avail_end = '0;
  int n_cmp = 0, n_err = 0;

  typedef struct {
    logic [15:0] pc, end_pc;
    op_e         op;
    logic        fault;
    logic [3:0]  pcnt;
    seg_e        seg;
    rep_e        rep;
    logic        mrd;
    logic [15:0] imm;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  nec_decode_pipe #(.IPQ_DEPTH(IPQ_DEPTH), .OUT_DEPTH(OUT_DEPTH), .MAX_PREFIX(MAX_PREFIX)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .set_pc(set_pc), .new_pc(new_pc),
    .ipq_len(ipq_len), .ipq(ipq), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_entry(out_entry), .idle(idle)
  );

  // IPQ owner: bytes [pc, avail_end) are resident, capped at the queue depth
  always_comb begin
    diff    = avail_end - pc;
    ipq_len = (diff > 16'd8) ? 4'd8 : diff[3:0];
    for (int s = 0; s < IPQ_DEPTH; s++) ipq[s] = mem[pc + {13'd0, 3'(s) - pc[2:0]}];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] p, input logic [15:0] e, input op_e op,
                              input logic f, input logic [3:0] n, input seg_e s, input rep_e r,
                              input logic m, input logic [15:0] i);
    exp_t x;
    x.pc = p; x.end_pc = e; x.op = op; x.fault = f; x.pcnt = n;
    x.seg = s; x.rep = r; x.mrd = m; x.imm = i;
    return x;
  endfunction

  always @(negedge clk) begin
    if (reset_n && ce && !set_pc && out_valid && out_ready) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        me = sb.pop_front();
        chk("e_pc",     32'(out_entry.d.pc),         32'(me.pc));
        chk("e_end_pc", 32'(out_entry.d.end_pc),     32'(me.end_pc));
        chk("e_opcode", 32'(out_entry.d.opcode),     32'(me.op));
        chk("e_fault",  32'(out_entry.fault),        32'(me.fault));
        chk("e_pcnt",   32'(out_entry.prefix_count), 32'(me.pcnt));
        chk("e_seg",    32'(out_entry.d.segment),    32'(me.seg));
        chk("e_rep",    32'(out_entry.d.rep),        32'(me.rep));
        chk("e_mrd",    32'(out_entry.d.mem_read),   32'(me.mrd));
        chk("e_imm",    32'(out_entry.d.imm[15:0]),  32'(me.imm));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0; set_pc = 1'b0; ce = 1'b1; out_ready = 1'b0; avail_end = '0;
    sb.delete();
    step(2);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    // 1: single NOP, first record after the 4th edge
    hold_reset();
    mem[0] = 8'h90; avail_end = 16'd1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_entry_nz", 32'(out_entry != '0), 32'd0);
    sb.push_back(mk(16'd0, 16'd1, OP_NOP, 1'b0, 4'd0, DS0, REPEAT_NONE, 1'b0, 16'h0));
    out_ready = 1'b1;
    release_reset();
    step(3);
    chk("t1_valid_e3", 32'(out_valid), 32'd0);
    step(1);
    chk("t1_valid_e4", 32'(out_valid), 32'd1);
    chk("t1_pc", 32'(pc), 32'd1);
    step(1);
    chk("t1_idle", 32'(idle), 32'd1);
    drain(10);

    // 2: segment + repeat prefixes
    hold_reset();
    mem[0] = 8'h26; mem[1] = 8'hF3; mem[2] = 8'hA4; avail_end = 16'd3;
    sb.push_back(mk(16'd0, 16'd3, OP_MOVBK, 1'b0, 4'd2, DS1, REPEAT_Z, 1'b0, 16'h0));
    out_ready = 1'b1;
    release_reset();
    drain(30);
    chk("t2_pc", 32'(pc), 32'd3);

    // 3: immediate split across the 0xFFFF wrap, bytes trickling in
    hold_reset();
    out_ready = 1'b1;
    release_reset();
    step(2);
    mem[16'hFFFE] = 8'hB8; mem[16'hFFFF] = 8'h34; mem[0] = 8'h12;
    set_pc = 1'b1; new_pc = 16'hFFFE; avail_end = 16'hFFFE;
    step(1);
    set_pc = 1'b0;
    chk("t3_setpc", 32'(pc), 32'hFFFE);
    sb.push_back(mk(16'hFFFE, 16'h0001, OP_MOV_RI, 1'b0, 4'd0, DS0, REPEAT_NONE, 1'b0, 16'h1234));
    avail_end = 16'hFFFF; step(4);
    avail_end = 16'h0000; step(4);
    chk("t3_stall_valid", 32'(out_valid), 32'd0);
    chk("t3_stall_pc", 32'(pc), 32'hFFFF);
    avail_end = 16'h0001;
    drain(20);
    chk("t3_pc", 32'(pc), 32'h0001);

    // 4: backpressure with a full FIFO, ce freeze, pop-and-push in one cycle
    hold_reset();
    for (int i = 0; i < 4; i++) begin
      mem[i] = 8'h90;
      sb.push_back(mk(16'(i), 16'(i + 1), OP_NOP, 1'b0, 4'd0, DS0, REPEAT_NONE, 1'b0, 16'h0));
    end
    avail_end = 16'd4;
    release_reset();
    step(20);
    chk("t4_full_valid", 32'(out_valid), 32'd1);
    chk("t4_hold_pc", 32'(pc), 32'd3);
    ce = 1'b0; out_ready = 1'b1;
    step(3);
    chk("t4_ce_pc", 32'(pc), 32'd3);
    chk("t4_ce_sb", 32'(sb.size()), 32'd4);
    ce = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("t4_pop_valid", 32'(out_valid), 32'd1);
    chk("t4_pop_pc", 32'(pc), 32'd3);
    out_ready = 1'b1;
    drain(40);
    chk("t4_pc", 32'(pc), 32'd4);

    // 5: prefix overflow fault, invalid opcode, ModRM segments, PREPARE immediate
    hold_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h26;
    mem[16] = 8'h90; mem[17] = 8'hD6;
    mem[18] = 8'h8B; mem[19] = 8'h46; mem[20] = 8'h10;
    mem[21] = 8'h26; mem[22] = 8'h8B; mem[23] = 8'h07;
    mem[24] = 8'hC8; mem[25] = 8'h10; mem[26] = 8'h00; mem[27] = 8'h02;
    avail_end = 16'd28;
    sb.push_back(mk(16'd0,  16'd15, OP_INVALID, 1'b1, 4'd15, DS1, REPEAT_NONE, 1'b0, 16'h0));
    sb.push_back(mk(16'd15, 16'd17, OP_NOP,     1'b0, 4'd1,  DS1, REPEAT_NONE, 1'b0, 16'h0));
    sb.push_back(mk(16'd17, 16'd18, OP_INVALID, 1'b0, 4'd0,  DS0, REPEAT_NONE, 1'b0, 16'h0));
    sb.push_back(mk(16'd18, 16'd21, OP_MOV,     1'b0, 4'd0,  SS,  REPEAT_NONE, 1'b1, 16'h0));
    sb.push_back(mk(16'd21, 16'd24, OP_MOV,     1'b0, 4'd1,  DS1, REPEAT_NONE, 1'b1, 16'h0));
    sb.push_back(mk(16'd24, 16'd28, OP_PREPARE, 1'b0, 4'd0,  DS0, REPEAT_NONE, 1'b0, 16'h0010));
    out_ready = 1'b1;
    release_reset();
    drain(200);
    chk("t5_pc", 32'(pc), 32'd28);

    // 6: flush mid-OPERANDS with a queued record, then async reset mid-decode
    hold_reset();
    mem[0] = 8'h90; mem[1] = 8'hB8; avail_end = 16'd2;
    release_reset();
    step(10);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_pc", 32'(pc), 32'd2);
    set_pc = 1'b1; new_pc = 16'h0100; out_ready = 1'b1; avail_end = 16'h0100;
    step(1);
    set_pc = 1'b0;
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    chk("t6_flush_pc", 32'(pc), 32'h0100);
    chk("t6_init_idle", 32'(idle), 32'd0);
    step(1);
    chk("t6_opcode_idle", 32'(idle), 32'd1);
    mem[16'h0100] = 8'h90; avail_end = 16'h0101;
    sb.push_back(mk(16'h0100, 16'h0101, OP_NOP, 1'b0, 4'd0, DS0, REPEAT_NONE, 1'b0, 16'h0));
    drain(20);
    out_ready = 1'b0;
    mem[16'h0101] = 8'h90; mem[16'h0102] = 8'hB8; avail_end = 16'h0103;
    step(8);
    chk("t6_mid_valid", 32'(out_valid), 32'd1);
    chk("t6_mid_pc", 32'(pc), 32'h0103);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_arst_valid", 32'(out_valid), 32'd0);
    chk("t6_arst_pc", 32'(pc), 32'd0);
    chk("t6_arst_idle", 32'(idle), 32'd0);
    chk("t6_arst_entry_nz", 32'(out_entry != '0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
